// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: arbiter state encodings and default watchdog limit
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_t;
  localparam int ARB_TIMEOUT = 255;
endpackage

// File: rtl/mem_arbiter_timeout_cnt.sv
// arb_timeout_cnt: clearable enabled watchdog counter with terminal-count flag
//   clk, rst (async active-low), clr (restart), en (count this cycle),
//   tc (this enabled cycle is the TIMEOUT-th; never set when TIMEOUT == 0)
module arb_timeout_cnt #(
  parameter int TIMEOUT = mem_arbiter_pkg::ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  // fires while the TIMEOUT-th busy cycle without ack is in progress
  assign tc = (TIMEOUT != 0) && en && (cnt == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access
//   i_*: instruction read requester (req/addr in, rdata/ack/err out)
//   d_*: data requester (req/wr/addr/wdata/sel in, rdata/ack/err out)
//   stall_i/stall_d: hazard-unit stalls; m_*: registered memory port, m_rdata/m_ack in
//   rst: asynchronous active-low reset
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = ARB_TIMEOUT,
  parameter int DATA_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_sel,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_err,
  output logic                stall_i,
  output logic                stall_d,
  output logic                m_req,
  output logic                m_wr,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_sel,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack
);
  arb_state_t state;
  logic idle, busy_i, busy_d, tout, gnt_i, gnt_d, done;
  assign idle   = state == ARB_IDLE;
  assign busy_i = state == ARB_BUSY_I;
  assign busy_d = state == ARB_BUSY_D;
  arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(gnt_i | gnt_d),
    .en (~idle & ~m_ack),
    .tc (tout)
  );
  // from IDLE the priority parameter decides; on an ack only the other side may chain in
  assign gnt_d = d_req & (idle ? (DATA_FIRST != 0 || !i_req) : (busy_i & m_ack));
  assign gnt_i = i_req & ~gnt_d & (idle | (busy_d & m_ack));
  assign done  = ~idle & (m_ack | tout);
  assign i_ack   = busy_i & m_ack;
  assign d_ack   = busy_d & m_ack;
  assign i_err   = busy_i & tout;
  assign d_err   = busy_d & tout;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign stall_i = i_req & ~i_ack;
  assign stall_d = d_req & ~d_ack;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= ARB_IDLE;
      m_req   <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_sel   <= '0;
    end else if (gnt_d) begin
      state   <= ARB_BUSY_D;
      m_req   <= 1'b1;
      m_wr    <= d_wr;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_sel   <= d_sel;
    end else if (gnt_i) begin
      state   <= ARB_BUSY_I;
      m_req   <= 1'b1;
      m_wr    <= 1'b0;
      m_addr  <= i_addr;
      m_wdata <= '0;
      m_sel   <= '1;
    end else if (done) begin
      state   <= ARB_IDLE;
      m_req   <= 1'b0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk, rst;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_sel, m_sel;
  logic        stall_i, stall_d, m_req, m_wr, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int checks, failures;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .DATA_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .stall_i(stall_i), .stall_d(stall_d),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; m_ack = 1'b1;
    #2;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rst_m_req got=%h exp=0", m_req); end
    checks++; if (m_addr !== 32'h0) begin failures++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end
    checks++; if (m_sel !== 4'h0 || m_wr !== 1'b0 || m_wdata !== 32'h0) begin failures++; $display("FAIL rst_m_fields got sel=%h wr=%h wdata=%h exp=0", m_sel, m_wr, m_wdata); end
    checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0) begin failures++; $display("FAIL rst_acks got=%b exp=0000", {i_ack, d_ack, i_err, d_err}); end
    tick; rst = 1'b1; m_ack = 1'b0;
    #3;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rst_release_m_req got=%h exp=0", m_req); end
  endtask

  task automatic test_single_read;
    tick; i_req = 1'b1; i_addr = 32'hBFC00000;
    #3;
    checks++; if (m_req !== 1'b0 || stall_i !== 1'b1) begin failures++; $display("FAIL rd_req_cycle got m_req=%h stall_i=%h exp 0/1", m_req, stall_i); end
    tick; #3;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'hBFC00000) begin failures++; $display("FAIL rd_m_addr got req=%h addr=%h exp 1/bfc00000", m_req, m_addr); end
    checks++; if (m_wr !== 1'b0 || m_sel !== 4'hF || m_wdata !== 32'h0) begin failures++; $display("FAIL rd_m_fields got wr=%h sel=%h wdata=%h exp 0/f/0", m_wr, m_sel, m_wdata); end
    checks++; if (i_ack !== 1'b0 || stall_i !== 1'b1) begin failures++; $display("FAIL rd_wait1 got ack=%h stall=%h exp 0/1", i_ack, stall_i); end
    tick; #3;
    checks++; if (i_ack !== 1'b0 || stall_i !== 1'b1) begin failures++; $display("FAIL rd_wait2 got ack=%h stall=%h exp 0/1", i_ack, stall_i); end
    tick; m_ack = 1'b1; m_rdata = 32'h24080001;
    #3;
    checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h24080001) begin failures++; $display("FAIL rd_ack got ack=%h rdata=%h exp 1/24080001", i_ack, i_rdata); end
    checks++; if (stall_i !== 1'b0 || i_err !== 1'b0 || d_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_side got stall=%h err=%h d_ack=%h exp 0/0/0", stall_i, i_err, d_ack); end
    tick; i_req = 1'b0; m_ack = 1'b0;
    #3;
    checks++; if (i_ack !== 1'b0 || m_req !== 1'b0) begin failures++; $display("FAIL rd_after got ack=%h m_req=%h exp 0/0", i_ack, m_req); end
  endtask

  task automatic test_data_write;
    tick; d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h80000010; d_wdata = 32'hDEADBEEF; d_sel = 4'b0011;
    #3;
    tick; #3;
    checks++; if (m_req !== 1'b1 || m_wr !== 1'b1 || m_addr !== 32'h80000010) begin failures++; $display("FAIL wr_m_ctl got req=%h wr=%h addr=%h exp 1/1/80000010", m_req, m_wr, m_addr); end
    checks++; if (m_wdata !== 32'hDEADBEEF || m_sel !== 4'b0011) begin failures++; $display("FAIL wr_m_data got wdata=%h sel=%h exp deadbeef/3", m_wdata, m_sel); end
    checks++; if (stall_d !== 1'b1 || d_ack !== 1'b0) begin failures++; $display("FAIL wr_wait got stall=%h ack=%h exp 1/0", stall_d, d_ack); end
    tick; m_ack = 1'b1; m_rdata = 32'h0;
    #3;
    checks++; if (d_ack !== 1'b1 || stall_d !== 1'b0 || i_ack !== 1'b0) begin failures++; $display("FAIL wr_ack got ack=%h stall=%h i_ack=%h exp 1/0/0", d_ack, stall_d, i_ack); end
    tick; d_req = 1'b0; m_ack = 1'b0;
    #3;
    checks++; if (d_ack !== 1'b0 || m_req !== 1'b0) begin failures++; $display("FAIL wr_after got ack=%h m_req=%h exp 0/0", d_ack, m_req); end
  endtask

  task automatic test_back_to_back;
    tick; i_req = 1'b1; i_addr = 32'h00400000;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h10010000; d_sel = 4'b1100;
    #3;
    tick; #3;
    checks++; if (m_addr !== 32'h10010000 || m_sel !== 4'b1100 || m_wr !== 1'b0) begin failures++; $display("FAIL b2b_first got addr=%h sel=%h wr=%h exp 10010000/c/0", m_addr, m_sel, m_wr); end
    checks++; if (stall_i !== 1'b1 || stall_d !== 1'b1) begin failures++; $display("FAIL b2b_stalls got i=%h d=%h exp 1/1", stall_i, stall_d); end
    tick; m_ack = 1'b1; m_rdata = 32'h11112222;
    #3;
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h11112222 || i_ack !== 1'b0) begin failures++; $display("FAIL b2b_d_ack got ack=%h rdata=%h i_ack=%h exp 1/11112222/0", d_ack, d_rdata, i_ack); end
    tick; d_req = 1'b0; m_ack = 1'b0;
    #3;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h00400000) begin failures++; $display("FAIL b2b_chain got req=%h addr=%h exp 1/00400000", m_req, m_addr); end
    checks++; if (m_sel !== 4'hF || m_wr !== 1'b0 || m_wdata !== 32'h0) begin failures++; $display("FAIL b2b_chain_fields got sel=%h wr=%h wdata=%h exp f/0/0", m_sel, m_wr, m_wdata); end
    tick; m_ack = 1'b1; m_rdata = 32'h33334444;
    #3;
    checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h33334444 || d_ack !== 1'b0) begin failures++; $display("FAIL b2b_i_ack got ack=%h rdata=%h d_ack=%h exp 1/33334444/0", i_ack, i_rdata, d_ack); end
    tick; i_req = 1'b0; m_ack = 1'b0;
    #3;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL b2b_idle got m_req=%h exp 0", m_req); end
  endtask

  task automatic test_timeout;
    tick; d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h80000020; d_wdata = 32'h12345678; d_sel = 4'hF;
    #3;
    for (int k = 1; k <= 4; k++) begin
      tick; #3;
      checks++; if (d_err !== (k == 4) || m_req !== 1'b1) begin failures++; $display("FAIL to_busy%0d got err=%h m_req=%h exp %0d/1", k, d_err, m_req, k == 4); end
    end
    tick; d_req = 1'b0;
    #3;
    checks++; if (m_req !== 1'b0 || d_err !== 1'b0 || d_ack !== 1'b0) begin failures++; $display("FAIL to_abort got m_req=%h err=%h ack=%h exp 0/0/0", m_req, d_err, d_ack); end
    tick; m_ack = 1'b1;
    #3;
    checks++; if (d_ack !== 1'b0 || i_ack !== 1'b0) begin failures++; $display("FAIL to_stale_ack got d=%h i=%h exp 0/0", d_ack, i_ack); end
    tick; m_ack = 1'b0;
    #3;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL to_stay_idle got m_req=%h exp 0", m_req); end
  endtask

  task automatic test_reset_mid;
    tick; i_req = 1'b1; i_addr = 32'hBFC00004;
    #3;
    tick; #3;
    checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL rm_busy got m_req=%h exp 1", m_req); end
    #2; rst = 1'b0;
    #1;
    checks++; if (m_req !== 1'b0 || m_addr !== 32'h0) begin failures++; $display("FAIL rm_async got m_req=%h addr=%h exp 0/0", m_req, m_addr); end
    tick; i_req = 1'b0; m_ack = 1'b1;
    #3;
    tick; rst = 1'b1;
    #3;
    checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin failures++; $display("FAIL rm_late_ack got i=%h d=%h exp 0/0", i_ack, d_ack); end
    tick; m_ack = 1'b0;
    #3;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rm_idle got m_req=%h exp 0", m_req); end
    tick; i_req = 1'b1; i_addr = 32'hBFC00008;
    #3;
    tick; m_ack = 1'b1; m_rdata = 32'h00000005;
    #3;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'hBFC00008) begin failures++; $display("FAIL rm_new_req got req=%h addr=%h exp 1/bfc00008", m_req, m_addr); end
    checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h5) begin failures++; $display("FAIL rm_new_ack got ack=%h rdata=%h exp 1/5", i_ack, i_rdata); end
    tick; i_req = 1'b0; m_ack = 1'b0;
    #3;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rm_done got m_req=%h exp 0", m_req); end
  endtask

  task automatic test_ack_at_timeout;
    tick; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h80000040; d_sel = 4'hF;
    #3;
    for (int k = 1; k <= 3; k++) begin
      tick; #3;
      checks++; if (d_err !== 1'b0) begin failures++; $display("FAIL at_busy%0d got err=%h exp 0", k, d_err); end
    end
    tick; m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    #3;
    checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL at_tc_ack got ack=%h err=%h rdata=%h exp 1/0/cafef00d", d_ack, d_err, d_rdata); end
    tick; d_req = 1'b0; m_ack = 1'b0;
    #3;
    checks++; if (m_req !== 1'b0 || d_err !== 1'b0) begin failures++; $display("FAIL at_after got m_req=%h err=%h exp 0/0", m_req, d_err); end
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;
    m_ack = 1'b0; m_rdata = '0;
    test_reset;
    test_single_read;
    test_data_write;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    test_ack_at_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
